// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, port indices, request payload and the range check.
package dmem_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   typedef logic [0:0] state_t;
   localparam state_t P0_PRIO  = 1'b0;
   localparam state_t P1_FORCE = 1'b1;

   localparam logic [0:0] PORT_CPU = 1'b0;
   localparam logic [0:0] PORT_ACC = 1'b1;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   // Byte address is legal when below 4*depth_words; the low two bits cannot change the outcome.
   function automatic logic in_range(input logic [ADDR_W-1:0] addr, input int unsigned depth_words);
      logic [ADDR_W+1:0] lim;
      lim = (ADDR_W+2)'(depth_words) << 2;
      return ((ADDR_W+2)'(addr) < lim);
   endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Starvation counter for the accelerator port; flags the edge where the limit is reached.
module dmem_starve_ctr #(
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic clk_50,
   input  logic rst,
   input  logic p1_req,
   input  logic p1_gnt,
   output logic hit_c
);

   localparam int unsigned CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);

   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // Count denied request cycles, saturating at the limit; any grant or idle cycle clears.
   always_comb begin
      cnt_nxt = '0;
      if (p1_req && !p1_gnt) begin
         if (starve_cnt != CNT_W'(STARVE_LIM))
            cnt_nxt = starve_cnt + CNT_W'(1);
         else
            cnt_nxt = starve_cnt;
      end
      hit_c = p1_req && !p1_gnt && (cnt_nxt == CNT_W'(STARVE_LIM));
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else
         starve_cnt <= cnt_nxt;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: CPU port has priority, accelerator port gets a forced
// slot after a bounded number of denied cycles. Read data returns one cycle after grant.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIM  = 4,
   parameter int unsigned DEPTH_WORDS = 1024
) (
   input  logic              clk_50,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              p0_err,
   output logic              p1_err,
   output logic              MEMRead,
   output logic              MEMWrite,
   output logic [ADDR_W-1:0] ADDR,
   output logic [ADDR_W-1:0] WD,
   input  logic [DATA_W-1:0] RD
);

   state_t      state;
   state_t      state_nxt;
   req_t        p0_bus;
   req_t        p1_bus;
   req_t        sel;
   logic        gnt_any;
   logic        in_rng;
   logic        hit_c;
   logic [0:0]  rsp_tag;
   logic        rsp_oor;

   assign p0_bus = {p0_we, p0_addr, p0_wdata};
   assign p1_bus = {p1_we, p1_addr, p1_wdata};

   dmem_starve_ctr #(
      .STARVE_LIM (STARVE_LIM)
   ) u_starve_ctr (
      .clk_50 (clk_50),
      .rst    (rst),
      .p1_req (p1_req),
      .p1_gnt (p1_gnt),
      .hit_c  (hit_c)
   );

   // Grant decode and memory command drive; everything is quiet while reset is high.
   always_comb begin
      p0_gnt   = 1'b0;
      p1_gnt   = 1'b0;
      gnt_any  = 1'b0;
      sel      = '0;
      in_rng   = 1'b0;
      MEMRead  = 1'b0;
      MEMWrite = 1'b0;
      ADDR     = '0;
      WD       = '0;
      if (!rst) begin
         if (state == P1_FORCE) begin
            p1_gnt = p1_req;
         end else if (p0_req) begin
            p0_gnt = 1'b1;
         end else begin
            p1_gnt = p1_req;
         end
         gnt_any = p0_gnt || p1_gnt;
         sel     = p1_gnt ? p1_bus : p0_bus;
         in_rng  = in_range(sel.addr, DEPTH_WORDS);
         if (gnt_any && in_rng) begin
            MEMRead  = !sel.we;
            MEMWrite = sel.we;
            ADDR     = sel.addr;
            WD       = sel.wdata;
         end
      end
   end

   // Forced slot lasts exactly one cycle, whether or not the accelerator still requests.
   always_comb begin
      state_nxt = state;
      case (state)
         P0_PRIO:  if (hit_c) state_nxt = P1_FORCE;
         P1_FORCE: state_nxt = P0_PRIO;
         default:  state_nxt = P0_PRIO;
      endcase
   end

   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst)
         state <= P0_PRIO;
      else
         state <= state_nxt;
   end

   // Response bookkeeping: the tag remembers which port owns the read in flight.
   always_ff @(posedge clk_50 or posedge rst) begin
      if (rst) begin
         rsp_tag   <= PORT_CPU;
         rsp_oor   <= 1'b0;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_err    <= 1'b0;
         p1_err    <= 1'b0;
      end else begin
         p0_rvalid <= p0_gnt && !p0_we;
         p1_rvalid <= p1_gnt && !p1_we;
         p0_err    <= p0_gnt && !in_rng;
         p1_err    <= p1_gnt && !in_rng;
         if (gnt_any && !sel.we) begin
            rsp_tag <= p1_gnt ? PORT_ACC : PORT_CPU;
            rsp_oor <= !in_rng;
         end
      end
   end

   // Memory data is only forwarded to the tagged owner of an in-range read.
   always_comb begin
      p0_rdata = '0;
      p1_rdata = '0;
      if (!rsp_oor) begin
         if (p0_rvalid && (rsp_tag == PORT_CPU)) p0_rdata = RD;
         if (p1_rvalid && (rsp_tag == PORT_ACC)) p1_rdata = RD;
      end
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIM, default 4: consecutive denied cycles of port 1 before a forced grant.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 1024: data-memory depth in 32-bit words; legal byte range 0 .. 4*DEPTH_WORDS-1.
REQ-003 clk_50  input  1  clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 p0_req / p1_req  input  1  access request, port 0 = CPU load/store, port 1 = accelerator/DMA.
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  32  byte address.
REQ-008 p0_wdata / p1_wdata  input  32  write data.
REQ-009 p0_gnt / p1_gnt  output  1  combinational grant; a transfer occurs in a cycle where req and gnt are both high.
REQ-010 p0_rvalid / p1_rvalid  output  1  registered; read data valid for that port.
REQ-011 p0_rdata / p1_rdata  output  32  read data; 0 whenever the matching rvalid is low.
REQ-012 p0_err / p1_err  output  1  registered one-cycle pulse for an out-of-range access.
REQ-013 MEMRead, MEMWrite  output  1  memory commands.
REQ-014 ADDR, WD  output  32  memory address and write data.
REQ-015 RD  input  32  memory read data, valid one cycle after MEMRead; undefined/high-Z otherwise.

Function
REQ-016 At most one port SHALL be granted per cycle, and gnt SHALL never assert without the matching req.
REQ-017 FSM states SHALL be P0_PRIO and P1_FORCE.
REQ-018 In P0_PRIO, p0_req wins, else p1_req wins.
REQ-019 In P1_FORCE, p1 SHALL be granted unconditionally; the FSM then returns to P0_PRIO.
REQ-020 starve_cnt SHALL increment in each cycle p1_req=1 and p1 is not granted, and SHALL clear on any p1 grant or when p1_req=0.
REQ-021 P0_PRIO SHALL transition to P1_FORCE at the edge where starve_cnt reaches STARVE_LIM.
REQ-022 A p1 request dropped while in P1_FORCE SHALL return the FSM to P0_PRIO without a grant.
REQ-023 For a granted in-range access, MEMWrite=we, MEMRead=~we, ADDR=addr and WD=wdata of the winner, all in the same cycle; all four outputs SHALL be 0 when there is no grant.
REQ-024 In-range SHALL mean addr < 4*DEPTH_WORDS; addr[1:0] is ignored (word access).
REQ-025 An out-of-range access SHALL be granted but SHALL drive MEMRead=MEMWrite=0, and that port's err SHALL pulse the next cycle.
REQ-026 An out-of-range read SHALL also assert that port's rvalid the next cycle with rdata=0.
REQ-027 An in-range read SHALL store the owner in a registered tag; the next cycle that port's rvalid=1 and rdata=RD; the other port's rdata=0.
REQ-028 Back-to-back reads SHALL be sustained at one per cycle, including alternating ports, with each response routed by its own tag.
REQ-029 A write SHALL produce no rvalid.
REQ-030 Read latency SHALL be exactly 1 cycle from grant to rvalid.

Reset
REQ-031 On rst: FSM=P0_PRIO, starve_cnt=0, tag cleared, all rvalid/err=0, all rdata=0.
REQ-032 Combinational outputs SHALL be 0 while rst is high.
REQ-033 A read granted in the cycle rst asserts SHALL produce no rvalid.

Structure
REQ-034 A shared package SHALL hold the FSM state typedef and the port-index constants (PORT_CPU=0, PORT_ACC=1).
REQ-035 One sub-module dmem_starve_ctr SHALL hold the starvation counter and the limit compare; all else is flat.

Verification
REQ-036 Only p0 reads addr 0x8 with RD=3 the next cycle -> p0_gnt=1, MEMRead=1, ADDR=0x8; next cycle p0_rvalid=1, p0_rdata=3, p1_rvalid=0.
REQ-037 Both ports request continuously with STARVE_LIM=4 -> grants p0,p0,p0,p0,p1 then repeat; no cycle with both gnt high.
REQ-038 p0 writes 0xAB to 0x10, then p1 reads 0x10 the next cycle -> MEMWrite pulse with WD=0xAB, then p1_rvalid=1, p1_rdata=0xAB.
REQ-039 p1 reads 0x1000 (out of range, depth 1024) -> p1_gnt=1, MEMRead=0; next cycle p1_err=1, p1_rvalid=1, p1_rdata=0.
REQ-040 Alternating p0/p1 reads on consecutive cycles -> each rvalid lands on the correct port one cycle later.
REQ-041 Assert rst on the grant cycle of a read -> no rvalid; FSM=P0_PRIO.
